// File: rtl/kernel_interrupt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_irq_defs (package)
// Description : Shared FSM encoding, default widths and index-width helper
//               for the kernel interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_irq_defs;

   localparam int c_CTXW_DEFAULT  = 9;
   localparam int c_SRC_W_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2
   } irq_state_t;

   // Returns at least 1 so a single-entry index still has a legal width.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      if (result == 0) result = 1;
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_irq_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : kernel_irq_rr_arbiter
// Description : Combinational rotate-priority pick: first set bit of the
//               pending vector at or after the round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_irq_rr_arbiter
   import kernel_irq_defs::*;
#(
   parameter int NUM_KERNELS = 4,
   parameter int IDXW        = clog2(NUM_KERNELS)
)(
   input  logic [NUM_KERNELS-1:0] i_pending,
   input  logic [IDXW-1:0]        i_rr_ptr,
   output logic [IDXW-1:0]        o_grant,
   output logic                   o_valid
);

   logic [IDXW-1:0] w_idx [NUM_KERNELS];

   for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_rot
      logic [IDXW:0] w_sum;
      assign w_sum    = {1'b0, i_rr_ptr} + (IDXW+1)'(k);
      assign w_idx[k] = (w_sum >= (IDXW+1)'(NUM_KERNELS))
                        ? IDXW'(w_sum - (IDXW+1)'(NUM_KERNELS))
                        : IDXW'(w_sum);
   end

   // Scan from farthest to nearest so the nearest pending index wins.
   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      for (int k = NUM_KERNELS - 1; k >= 0; k--) begin
         if (i_pending[w_idx[k]]) begin
            o_grant = w_idx[k];
            o_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/kernel_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : kernel_interrupt_arbiter
// Description : Round-robin sharing of one upstream interrupt channel among
//               NUM_KERNELS kernels. Optional ack timeout when
//               KERNEL_IRQ_ACK_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_interrupt_arbiter
   import kernel_irq_defs::*;
#(
   parameter int NUM_KERNELS    = 4,
   parameter int CTXW           = c_CTXW_DEFAULT,
   parameter int SRC_W          = c_SRC_W_DEFAULT,
   parameter int TIMEOUT_CYCLES = 4096
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_KERNELS-1:0]      k_irq_req,
   input  logic [NUM_KERNELS*SRC_W-1:0] k_irq_src,
   input  logic [NUM_KERNELS*CTXW-1:0] k_irq_ctx,
   output logic [NUM_KERNELS-1:0]      k_irq_ack,
   output logic                        irq_req,
   output logic [SRC_W-1:0]            irq_src,
   output logic [CTXW-1:0]             irq_ctx,
   input  logic                        irq_ack,
   output logic [NUM_KERNELS-1:0]      irq_pending,
   output logic                        irq_busy,
   output logic [NUM_KERNELS-1:0]      err_overrun,
   output logic                        err_timeout,
   input  logic                        err_clr
);

   localparam int c_IDXW = clog2(NUM_KERNELS);

   irq_state_t             r_state;
   irq_state_t             w_state_nxt;
   logic [NUM_KERNELS-1:0] r_pending;
   logic [SRC_W-1:0]       r_cap_src [NUM_KERNELS];
   logic [CTXW-1:0]        r_cap_ctx [NUM_KERNELS];
   logic [c_IDXW-1:0]      r_rr_ptr;
   logic [c_IDXW-1:0]      r_grant;
   logic [c_IDXW-1:0]      w_pick;
   logic                   w_pick_valid;
   logic                   w_take;
   logic                   w_retire;
   logic                   w_timeout;
   logic [NUM_KERNELS-1:0] w_retire_vec;
   logic [NUM_KERNELS-1:0] w_accept;
   logic [NUM_KERNELS-1:0] w_overrun_set;
   logic [NUM_KERNELS-1:0] r_k_irq_ack;
   logic [NUM_KERNELS-1:0] r_err_overrun;
   logic [SRC_W-1:0]       r_irq_src;
   logic [CTXW-1:0]        r_irq_ctx;

   kernel_irq_rr_arbiter #(
      .NUM_KERNELS (NUM_KERNELS),
      .IDXW        (c_IDXW)
   ) u_rr (
      .i_pending (r_pending),
      .i_rr_ptr  (r_rr_ptr),
      .o_grant   (w_pick),
      .o_valid   (w_pick_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Arbitration is held off while a retire ack is being pulsed, giving the
   // ack-to-next-request spacing of three cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_retire    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_valid && (r_k_irq_ack == '0)) begin
               w_take      = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE:    w_state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            if (irq_ack || w_timeout) begin
               w_retire    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default:  w_state_nxt = IDLE;
      endcase
   end

   assign w_retire_vec = w_retire ? (NUM_KERNELS'(1) << r_grant) : '0;

   for (genvar i = 0; i < NUM_KERNELS; i++) begin : g_kernel
      assign w_accept[i]      = k_irq_req[i] && (!r_pending[i] || w_retire_vec[i]);
      assign w_overrun_set[i] = k_irq_req[i] && r_pending[i] && !w_retire_vec[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending <= '0;
         for (int i = 0; i < NUM_KERNELS; i++) begin
            r_cap_src[i] <= '0;
            r_cap_ctx[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_KERNELS; i++) begin
            if (w_accept[i]) begin
               r_pending[i] <= 1'b1;
               r_cap_src[i] <= k_irq_src[i*SRC_W +: SRC_W];
               r_cap_ctx[i] <= k_irq_ctx[i*CTXW +: CTXW];
            end else if (w_retire_vec[i]) begin
               r_pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grant     <= '0;
         r_rr_ptr    <= '0;
         r_irq_src   <= '0;
         r_irq_ctx   <= '0;
         r_k_irq_ack <= '0;
      end else begin
         r_k_irq_ack <= w_retire_vec;
         if (w_take) begin
            r_grant   <= w_pick;
            r_irq_src <= r_cap_src[w_pick];
            r_irq_ctx <= r_cap_ctx[w_pick];
         end
         if (w_retire) begin
            r_rr_ptr <= (r_grant == c_IDXW'(NUM_KERNELS - 1)) ? '0
                                                               : r_grant + c_IDXW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_err_overrun <= '0;
      else if (err_clr) r_err_overrun <= '0;
      else              r_err_overrun <= r_err_overrun | w_overrun_set;
   end

`ifdef KERNEL_IRQ_ACK_TIMEOUT_EN
   localparam int c_TOW = clog2(TIMEOUT_CYCLES) + 1;

   logic [c_TOW-1:0] r_to_cnt;
   logic             r_err_timeout;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    r_to_cnt <= '0;
      else if (r_state == ISSUE)    r_to_cnt <= '0;
      else if (r_state == WAIT_ACK) r_to_cnt <= r_to_cnt + c_TOW'(1);
   end

   assign w_timeout = (r_state == WAIT_ACK) && (r_to_cnt == c_TOW'(TIMEOUT_CYCLES - 1));

   // A real ack in the expiry cycle wins and suppresses the error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        r_err_timeout <= 1'b0;
      else if (err_clr)                 r_err_timeout <= 1'b0;
      else if (w_timeout && !irq_ack)   r_err_timeout <= 1'b1;
   end

   assign err_timeout = r_err_timeout;
`else
   assign w_timeout   = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign k_irq_ack   = r_k_irq_ack;
   assign irq_req     = (r_state == ISSUE);
   assign irq_src     = r_irq_src;
   assign irq_ctx     = r_irq_ctx;
   assign irq_pending = r_pending;
   assign irq_busy    = (r_state != IDLE);
   assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_kernel_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_interrupt_arbiter
// Description : Directed bench with a cycle-accurate behavioural reference
//               for kernel_interrupt_arbiter (timeout case with
//               KERNEL_IRQ_ACK_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_interrupt_arbiter;

   localparam int N     = 4;
   localparam int CTXW  = 9;
   localparam int SRC_W = 64;
   localparam int TMO   = 16;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [N-1:0]       k_irq_req = '0;
   logic [N*SRC_W-1:0] k_irq_src = '0;
   logic [N*CTXW-1:0]  k_irq_ctx = '0;
   logic [N-1:0]       k_irq_ack;
   logic               irq_req;
   logic [SRC_W-1:0]   irq_src;
   logic [CTXW-1:0]    irq_ctx;
   logic               irq_ack = 1'b0;
   logic [N-1:0]       irq_pending;
   logic               irq_busy;
   logic [N-1:0]       err_overrun;
   logic               err_timeout;
   logic               err_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ack_count = 0;

   kernel_interrupt_arbiter #(
      .NUM_KERNELS    (N),
      .CTXW           (CTXW),
      .SRC_W          (SRC_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .k_irq_req   (k_irq_req),
      .k_irq_src   (k_irq_src),
      .k_irq_ctx   (k_irq_ctx),
      .k_irq_ack   (k_irq_ack),
      .irq_req     (irq_req),
      .irq_src     (irq_src),
      .irq_ctx     (irq_ctx),
      .irq_ack     (irq_ack),
      .irq_pending (irq_pending),
      .irq_busy    (irq_busy),
      .err_overrun (err_overrun),
      .err_timeout (err_timeout),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference state: pending set with captures, one outstanding grant and
   // the cycle numbers at which it issues / may next be arbitrated.
   logic [N-1:0]     m_pend, m_kack, m_ovr;
   logic             m_to;
   logic [SRC_W-1:0] m_psrc [N];
   logic [CTXW-1:0]  m_pctx [N];
   logic [SRC_W-1:0] m_src;
   logic [CTXW-1:0]  m_ctx;
   bit               m_active;
   int               m_issue, m_free, m_rr, m_grant;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic void m_reset();
      m_pend = '0; m_kack = '0; m_ovr = '0; m_to = 1'b0;
      m_src = '0; m_ctx = '0; m_active = 0;
      m_issue = 0; m_free = 0; m_rr = 0; m_grant = 0;
      for (int i = 0; i < N; i++) begin
         m_psrc[i] = '0;
         m_pctx[i] = '0;
      end
   endfunction

   function automatic void m_step();
      logic [N-1:0] nkack;
      logic [N-1:0] ovr_set;
      bit retire, tmo, set_to, found;
      int rg;
      nkack = '0; ovr_set = '0; retire = 0; tmo = 0; set_to = 0; found = 0; rg = 0;
      if (m_active && cyc > m_issue) begin
`ifdef KERNEL_IRQ_ACK_TIMEOUT_EN
         tmo = (cyc == m_issue + TMO);
`endif
         if (irq_ack || tmo) begin
            retire    = 1;
            rg        = m_grant;
            nkack[rg] = 1'b1;
            m_rr      = (rg + 1) % N;
            m_free    = cyc + 2;
            m_active  = 0;
            set_to    = !irq_ack;
         end
      end else if (!m_active && cyc >= m_free && m_pend != '0) begin
         for (int k = 0; k < N; k++) begin
            if (!found && m_pend[(m_rr + k) % N]) begin
               m_grant = (m_rr + k) % N;
               found   = 1;
            end
         end
         m_active = 1;
         m_issue  = cyc + 1;
         m_src    = m_psrc[m_grant];
         m_ctx    = m_pctx[m_grant];
      end
      for (int i = 0; i < N; i++) begin
         if (k_irq_req[i]) begin
            if (!m_pend[i] || (retire && i == rg)) begin
               m_pend[i] = 1'b1;
               m_psrc[i] = k_irq_src[i*SRC_W +: SRC_W];
               m_pctx[i] = k_irq_ctx[i*CTXW +: CTXW];
            end else begin
               ovr_set[i] = 1'b1;
            end
         end else if (retire && i == rg) begin
            m_pend[i] = 1'b0;
         end
      end
      if (err_clr) begin
         m_ovr = '0;
         m_to  = 1'b0;
      end else begin
         m_ovr = m_ovr | ovr_set;
         if (set_to) m_to = 1'b1;
      end
      m_kack = nkack;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         m_reset();
      end else begin
         check("irq_req",     irq_req,     64'(m_active && cyc == m_issue));
         check("irq_busy",    irq_busy,    64'(m_active && cyc >= m_issue));
         check("irq_src",     irq_src,     m_src);
         check("irq_ctx",     irq_ctx,     64'(m_ctx));
         check("k_irq_ack",   k_irq_ack,   64'(m_kack));
         check("irq_pending", irq_pending, 64'(m_pend));
         check("err_overrun", err_overrun, 64'(m_ovr));
         check("err_timeout", err_timeout, 64'(m_to));
         if (k_irq_ack != '0) ack_count++;
         m_step();
      end
   end

   task automatic step(input logic [N-1:0] req, input logic ack);
      k_irq_req = req;
      irq_ack   = ack;
      @(posedge clk);
      #1;
      k_irq_req = '0;
      irq_ack   = 1'b0;
   endtask

   task automatic idle_until(input int c);
      while (cyc < c) step('0, 1'b0);
   endtask

   task automatic set_kernel(input int i, input logic [SRC_W-1:0] s, input logic [CTXW-1:0] c);
      k_irq_src[i*SRC_W +: SRC_W] = s;
      k_irq_ctx[i*CTXW +: CTXW]   = c;
   endtask

   task automatic wait_irq(output int at);
      at = -1;
      for (int n = 0; n < 60 && at < 0; n++) begin
         if (irq_req) at = cyc;
         else         step('0, 1'b0);
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL wait_irq: no irq_req within 60 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int t0, at, at2, a, n;
      logic [SRC_W-1:0] exp_src [2];

      do_reset();
      check("rst_pending", irq_pending, 0);
      check("rst_busy",    irq_busy,    0);
      check("rst_kack",    k_irq_ack,   0);

      // Single request on an idle system.
      set_kernel(2, 64'hDEAD_0000_0000_1000, 9'h05);
      idle_until(10);
      t0 = cyc;
      step(4'b0100, 1'b0);
      wait_irq(at);
      check("s1_req_latency", 64'(at - t0), 2);
      check("s1_src", irq_src, 64'hDEAD_0000_0000_1000);
      check("s1_ctx", irq_ctx, 9'h05);
      idle_until(at + 8);
      step('0, 1'b1);
      check("s1_kack",    k_irq_ack,   4'b0100);
      check("s1_pending", irq_pending, 4'b0000);

      // All kernels at once, then kernels 0 and 3 again.
      do_reset();
      for (int i = 0; i < N; i++) set_kernel(i, 64'h1000 + 64'(i), 9'h10 + 9'(i));
      step(4'b1111, 1'b0);
      for (int k = 0; k < N; k++) begin
         wait_irq(at);
         check("s2_order", irq_src, 64'h1000 + 64'(k));
         idle_until(at + 3);
         step('0, 1'b1);
      end
      set_kernel(0, 64'h2000, 9'h20);
      set_kernel(3, 64'h2003, 9'h23);
      step(4'b1001, 1'b0);
      exp_src[0] = 64'h2000;
      exp_src[1] = 64'h2003;
      for (int k = 0; k < 2; k++) begin
         wait_irq(at);
         check("s2_reorder", irq_src, exp_src[k]);
         idle_until(at + 3);
         step('0, 1'b1);
      end

      // Overrun on kernel 1 while kernel 0 awaits ack.
      set_kernel(0, 64'h3000, 9'h30);
      set_kernel(1, 64'h3100, 9'h31);
      step(4'b0001, 1'b0);
      wait_irq(at);
      step('0, 1'b0);
      step(4'b0010, 1'b0);
      set_kernel(1, 64'h3111, 9'h3F);
      idle_until(at + 6);
      step(4'b0010, 1'b0);
      check("s3_overrun", err_overrun, 4'b0010);
      check("s3_pending", irq_pending, 4'b0011);
      step('0, 1'b1);
      wait_irq(at2);
      check("s3_first_src", irq_src, 64'h3100);
      check("s3_first_ctx", irq_ctx, 9'h31);
      idle_until(at2 + 2);
      step('0, 1'b1);
      err_clr = 1'b1;
      step('0, 1'b0);
      err_clr = 1'b0;
      check("s3_clr", err_overrun, 4'b0000);

      // Retire and re-pulse from the granted kernel in the same cycle.
      set_kernel(0, 64'h4000, 9'h40);
      step(4'b0001, 1'b0);
      wait_irq(at);
      idle_until(at + 2);
      a = cyc;
      set_kernel(0, 64'h4444, 9'h44);
      step(4'b0001, 1'b1);
      wait_irq(at2);
      check("s4_ack_to_req", 64'(at2 - a), 3);
      check("s4_new_src", irq_src, 64'h4444);
      check("s4_new_ctx", irq_ctx, 9'h44);
      check("s4_no_overrun", err_overrun, 4'b0000);
      idle_until(at2 + 1);
      step('0, 1'b1);
      step('0, 1'b0);

      // Asynchronous reset in WAIT_ACK.
      set_kernel(2, 64'h5200, 9'h52);
      step(4'b0100, 1'b0);
      wait_irq(at);
      step('0, 1'b0);
      step('0, 1'b0);
      n = ack_count;
      #1 reset = 1'b1;
      #1;
      check("s5_busy",    irq_busy,    0);
      check("s5_req",     irq_req,     0);
      check("s5_src",     irq_src,     0);
      check("s5_ctx",     irq_ctx,     0);
      check("s5_pending", irq_pending, 0);
      check("s5_kack",    k_irq_ack,   0);
      @(posedge clk);
      #1 reset = 1'b0;
      step('0, 1'b1);
      for (int i = 0; i < 3; i++) step('0, 1'b0);
      check("s5_no_ack", 64'(ack_count - n), 0);
      check("s5_idle",   irq_busy, 0);

`ifdef KERNEL_IRQ_ACK_TIMEOUT_EN
      // Timeout retires the grant; an ack in the expiry cycle wins.
      set_kernel(1, 64'h6100, 9'h61);
      set_kernel(2, 64'h6200, 9'h62);
      step(4'b0110, 1'b0);
      wait_irq(at);
      check("s6_first", irq_src, 64'h6100);
      idle_until(at + 17);
      check("s6_kack",    k_irq_ack,   4'b0010);
      check("s6_timeout", err_timeout, 1);
      wait_irq(at2);
      check("s6_next_lat", 64'(at2 - at), 19);
      check("s6_next_src", irq_src, 64'h6200);
      err_clr = 1'b1;
      step('0, 1'b0);
      err_clr = 1'b0;
      idle_until(at2 + 16);
      step('0, 1'b1);
      check("s6_ack_wins", err_timeout, 0);
      check("s6_kack2",    k_irq_ack,   4'b0100);
`else
      // No timeout: a long wait keeps the grant outstanding.
      set_kernel(1, 64'h6100, 9'h61);
      step(4'b0010, 1'b0);
      wait_irq(at);
      idle_until(at + 40);
      check("s6_still_busy", irq_busy, 1);
      check("s6_no_timeout", err_timeout, 0);
      step('0, 1'b1);
      check("s6_kack", k_irq_ack, 4'b0010);
`endif

      for (int i = 0; i < 4; i++) step('0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
